// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: default width and FSM state encoding.
package div_pkg;

  localparam int unsigned DIV_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step (combinational).
//   rem_in  : partial remainder, always < divisor
//   divisor : magnitude of the divisor
//   dvd_bit : next dividend bit, MSB first
//   rem_out : new partial remainder
//   q_bit   : quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dvd_bit,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // rem_in < divisor keeps shifted below 2*divisor, so diff[WIDTH] is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU in the EX stage.
//   clk, rst (async, active-low)
//   start, signed_div, cancel : control from the pipeline
//   a, b                      : dividend / divisor, sampled with start
//   busy                      : high in ITER and FIX (pipeline stall)
//   done                      : one-cycle pulse, quotient/remainder valid
//   quotient, remainder       : results to LO / HI, held until the next FIX
module div_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned    CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, shifts left as quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .divisor (dvs_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    abs_a   = (signed_div && a[WIDTH-1]) ? -a : a;
    abs_b   = (signed_div && b[WIDTH-1]) ? -b : b;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cnt_d  = '0;
          rem_d  = '0;
          dvs_d  = abs_b;
          qneg_d = signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = signed_div & a[WIDTH-1];
          div0_d = (b == '0);
          // Divide-by-zero keeps the raw dividend for the remainder and skips iteration.
          if (b == '0) begin
            dvd_d   = a;
            state_d = S_FIX;
          end else begin
            dvd_d   = abs_a;
            state_d = S_ITER;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ITER: begin
        dvd_d = {dvd_q[WIDTH-2:0], step_bit};
        rem_d = step_rem;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (div0_q) begin
          quo_d  = '1;
          remo_d = dvd_q;
        end else begin
          quo_d  = qneg_q ? -dvd_q : dvd_q;
          remo_d = rneg_q ? -rem_q : rem_q;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a FIX result write.
    if (cancel) begin
      state_d = S_IDLE;
      quo_d   = quo_q;
      remo_d  = remo_q;
    end

    busy_d = (state_d == S_ITER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = remo_q;

endmodule
